// File: rtl/spi_seq_pkg.sv
// Shared AHB encodings, AHBspi register offsets and sequencer state encoding.
// SPI_SEQ_READBACK_EN adds the MISO readback states.
package spi_seq_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [31:0] OFS_CTRL = 32'h0;
  localparam logic [31:0] OFS_SS   = 32'h4;
  localparam logic [31:0] OFS_DATA = 32'h8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_A,
    S_CFG_D,
    S_SS_A,
    S_SS_D,
    S_DAT_A,
    S_DAT_D,
    S_POLL_A,
    S_POLL_D,
    S_RESP
`ifdef SPI_SEQ_READBACK_EN
    ,
    S_RB_A,
    S_RB_D
`endif
  } seq_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_ADDR,
    X_DATA
  } xfer_phase_t;

endpackage

// File: rtl/ahb_single_xfer.sv
// One non-pipelined AHB-Lite transfer: a NONSEQ address phase, then an IDLE
// data phase held until hready. A new start may be launched on the completing edge.
module ahb_single_xfer
  import spi_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata
);

  xfer_phase_t phase;
  logic [31:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= X_IDLE;
      haddr   <= '0;
      htrans  <= HTRANS_IDLE;
      hwrite  <= 1'b0;
      hsize   <= HSIZE_WORD;
      hwdata  <= '0;
      wdata_q <= '0;
    end else if (hready) begin
      if (phase == X_ADDR) begin
        htrans <= HTRANS_IDLE;
        hwdata <= wdata_q;
        phase  <= X_DATA;
      end else if (phase == X_DATA) begin
        phase <= X_IDLE;
      end
      // A start on the completing edge overrides the return to idle.
      if (start && phase != X_ADDR) begin
        haddr   <= addr;
        hwrite  <= write;
        hsize   <= size;
        htrans  <= HTRANS_NONSEQ;
        wdata_q <= wdata;
        phase   <= X_ADDR;
      end
    end
  end

  assign busy  = (phase != X_IDLE);
  assign done  = (phase == X_DATA) && hready;
  assign rdata = hrdata;

endmodule

// File: rtl/spi_display_sequencer.sv
// AHB-Lite master that walks AHBspi through CTRL/SS/DATA writes and STATUS polling
// per request. SPI_SEQ_READBACK_EN adds a DATA readback whose word is returned.
//
// state    | meaning
// IDLE     | waiting for a request
// CFG_A/D  | CTRL write (first request after reset only)
// SS_A/D   | slave-select write (target differs from last one written)
// DAT_A/D  | DATA write, byte or halfword
// POLL_A/D | STATUS read until DONE_BIT or poll limit
// RB_A/D   | DATA readback (readback build only)
// RESP     | one-cycle response
module spi_display_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h5200_0000,
  parameter logic [31:0] CTRL_VALUE = 32'h0000_2040,
  parameter int          DONE_BIT   = 4,
  parameter int          POLL_LIMIT = 4096,
  parameter int          NSLAVES    = 32,
  localparam int         SSW        = $clog2(NSLAVES),
  localparam int         PCW        = $clog2(POLL_LIMIT) + 1
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [SSW-1:0] req_ss_i,
  input  logic           req_half_i,
  input  logic [15:0]    req_data_i,
  output logic           rsp_valid_o,
  output logic           rsp_err_o,
  output logic [31:0]    rsp_data_o,
  output logic [31:0]    HADDR,
  output logic [31:0]    HWDATA,
  output logic [1:0]     HTRANS,
  output logic           HWRITE,
  output logic [2:0]     HSIZE,
  input  logic [31:0]    HRDATA,
  input  logic           HREADY
);

  seq_state_t     state, nxt;
  logic           cfg_done, ss_valid, half_q, err_q;
  logic [SSW-1:0] last_ss, ss_q, eff_ss;
  logic [15:0]    data_q, eff_data;
  logic [PCW-1:0] poll_cnt;
  logic [31:0]    rsp_q;
  logic           eff_half, ss_hit, poll_ok, poll_last, accept;
  logic           x_start, x_write, x_busy, x_done;
  logic [31:0]    x_addr, x_wdata, x_rdata;
  logic [2:0]     x_size;

  // Accepting also needs a free bus so the first address phase can launch at once.
  assign req_ready_o = (state == S_IDLE) && !x_busy && HREADY;
  assign accept      = req_valid_i && req_ready_o;

  assign eff_ss    = (state == S_IDLE) ? req_ss_i   : ss_q;
  assign eff_half  = (state == S_IDLE) ? req_half_i : half_q;
  assign eff_data  = (state == S_IDLE) ? req_data_i : data_q;
  assign ss_hit    = ss_valid && (last_ss == eff_ss);
  assign poll_ok   = x_rdata[DONE_BIT];
  assign poll_last = (poll_cnt == PCW'(POLL_LIMIT - 1));

  always_comb begin
    nxt     = state;
    x_start = 1'b0;
    x_addr  = BASE_ADDR + OFS_CTRL;
    x_write = 1'b0;
    x_size  = HSIZE_WORD;
    x_wdata = '0;

    case (state)
      S_IDLE:   if (accept) nxt = !cfg_done ? S_CFG_A : (ss_hit ? S_DAT_A : S_SS_A);
      S_CFG_A:  if (HREADY) nxt = S_CFG_D;
      S_CFG_D:  if (x_done) nxt = ss_hit ? S_DAT_A : S_SS_A;
      S_SS_A:   if (HREADY) nxt = S_SS_D;
      S_SS_D:   if (x_done) nxt = S_DAT_A;
      S_DAT_A:  if (HREADY) nxt = S_DAT_D;
      S_DAT_D:  if (x_done) nxt = S_POLL_A;
      S_POLL_A: if (HREADY) nxt = S_POLL_D;
      S_POLL_D: begin
        if (x_done) begin
          if (poll_ok)
`ifdef SPI_SEQ_READBACK_EN
            nxt = S_RB_A;
`else
            nxt = S_RESP;
`endif
          else if (poll_last) nxt = S_RESP;
          else                nxt = S_POLL_A;
        end
      end
`ifdef SPI_SEQ_READBACK_EN
      S_RB_A:   if (HREADY) nxt = S_RB_D;
      S_RB_D:   if (x_done) nxt = S_RESP;
`endif
      S_RESP:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase

    // Launch the transfer belonging to whichever address state is being entered.
    if (nxt != state) begin
      case (nxt)
        S_CFG_A: begin
          x_start = 1'b1;
          x_write = 1'b1;
          x_addr  = BASE_ADDR + OFS_CTRL;
          x_wdata = CTRL_VALUE;
        end
        S_SS_A: begin
          x_start = 1'b1;
          x_write = 1'b1;
          x_addr  = BASE_ADDR + OFS_SS;
          x_wdata = 32'd1 << eff_ss;
        end
        S_DAT_A: begin
          x_start = 1'b1;
          x_write = 1'b1;
          x_addr  = BASE_ADDR + OFS_DATA;
          x_size  = eff_half ? HSIZE_HALF : HSIZE_BYTE;
          x_wdata = eff_half ? {16'h0, eff_data} : {24'h0, eff_data[7:0]};
        end
        S_POLL_A: begin
          x_start = 1'b1;
          x_addr  = BASE_ADDR + OFS_CTRL;
        end
`ifdef SPI_SEQ_READBACK_EN
        S_RB_A: begin
          x_start = 1'b1;
          x_addr  = BASE_ADDR + OFS_DATA;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      cfg_done <= 1'b0;
      ss_valid <= 1'b0;
      last_ss  <= '0;
      ss_q     <= '0;
      half_q   <= 1'b0;
      data_q   <= '0;
      poll_cnt <= '0;
      err_q    <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        ss_q     <= req_ss_i;
        half_q   <= req_half_i;
        data_q   <= req_data_i;
        poll_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (state == S_CFG_D && x_done) cfg_done <= 1'b1;
      if (state == S_SS_D && x_done) begin
        ss_valid <= 1'b1;
        last_ss  <= ss_q;
      end
      if (state == S_POLL_D && x_done) begin
        poll_cnt <= poll_cnt + PCW'(1);
        rsp_q    <= x_rdata;
        // A timed-out slave may be wedged; force SS to be rewritten next time.
        if (!poll_ok && poll_last) begin
          err_q    <= 1'b1;
          ss_valid <= 1'b0;
        end
      end
`ifdef SPI_SEQ_READBACK_EN
      if (state == S_RB_D && x_done) rsp_q <= x_rdata;
`endif
    end
  end

  assign rsp_valid_o = (state == S_RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_data_o  = rsp_valid_o ? rsp_q : '0;

  ahb_single_xfer u_xfer (
    .clk    (HCLK),
    .rst    (HRESET),
    .start  (x_start),
    .addr   (x_addr),
    .write  (x_write),
    .size   (x_size),
    .wdata  (x_wdata),
    .hready (HREADY),
    .hrdata (HRDATA),
    .busy   (x_busy),
    .done   (x_done),
    .rdata  (x_rdata),
    .haddr  (HADDR),
    .htrans (HTRANS),
    .hwrite (HWRITE),
    .hsize  (HSIZE),
    .hwdata (HWDATA)
  );

endmodule

// File: tb/tb_spi_display_sequencer.sv
// Bench for spi_display_sequencer: an AHB slave that plays AHBspi, plus a
// transaction-level model of the expected bus traffic and response per request.
module tb_spi_display_sequencer;

  localparam logic [31:0] BASE  = 32'h5200_0000;
  localparam logic [31:0] CTRL  = 32'h0000_2040;
  localparam int          LIMIT = 8;
`ifdef SPI_SEQ_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_ss = '0;
  logic        req_half = 1'b0;
  logic [15:0] req_data = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;

  always #5 clk = ~clk;

  spi_display_sequencer #(.POLL_LIMIT(LIMIT)) dut (
    .HCLK        (clk),
    .HRESET      (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_ss_i    (req_ss),
    .req_half_i  (req_half),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .rsp_data_o  (rsp_data),
    .HADDR       (haddr),
    .HWDATA      (hwdata),
    .HTRANS      (htrans),
    .HWRITE      (hwrite),
    .HSIZE       (hsize),
    .HRDATA      (hrdata),
    .HREADY      (hready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       cur;
  int          vectors = 0;
  int          miscompares = 0;
  bit          m_cfg_done = 0;
  bit          m_ss_valid = 0;
  logic [4:0]  m_ss = '0;
  bit          rsp_pending = 0;
  logic        exp_err = 0;
  logic [31:0] exp_data = '0;
  int          rsp_seen = 0;
  bit          in_data = 0;
  int          wait_left = 0;
  int          wait_mode = 0;
  int          xfer_cnt = 0;
  int          cur_idx = 0;
  int          polls_seen = 0;
  bit          prev_rsp = 0;
  logic [31:0] log_addr[16];
  logic [31:0] log_wdata[16];
  logic [2:0]  log_size[16];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endfunction

  // Expected traffic for one request, derived from the sequencing rules.
  function automatic void build(input logic [4:0] ss, input logic half,
                                input logic [15:0] d, input int done_at);
    xfer_t       x;
    int          n;
    logic        err;
    logic [31:0] last;
    last = '0;
    if (!m_cfg_done) begin
      x = '{BASE, 1'b1, 3'd2, CTRL, 32'h0};
      exp_q.push_back(x);
      m_cfg_done = 1;
    end
    if (!(m_ss_valid && m_ss == ss)) begin
      x = '{BASE + 32'h4, 1'b1, 3'd2, 32'h1 << ss, 32'h0};
      exp_q.push_back(x);
    end
    x = '{BASE + 32'h8, 1'b1, half ? 3'd1 : 3'd0,
          half ? {16'h0, d} : {24'h0, d[7:0]}, 32'h0};
    exp_q.push_back(x);
    err = (done_at > LIMIT);
    n = err ? LIMIT : done_at;
    for (int i = 1; i <= n; i++) begin
      x = '{BASE, 1'b0, 3'd2, 32'h0, $urandom};
      x.rdata[4] = (i == done_at);
      exp_q.push_back(x);
      last = x.rdata;
    end
    if (RB != 0 && !err) begin
      x = '{BASE + 32'h8, 1'b0, 3'd2, 32'h0, $urandom};
      exp_q.push_back(x);
      last = x.rdata;
    end
    exp_err = err;
    exp_data = last;
    rsp_pending = 1;
    if (err) m_ss_valid = 0;
    else begin
      m_ss_valid = 1;
      m_ss = ss;
    end
  endfunction

  // AHBspi slave and per-cycle compare against the expected traffic.
  always @(negedge clk) begin
    if (rst) begin
      in_data = 0;
      hready = 1'b1;
      prev_rsp = 0;
    end else begin
      if (in_data) begin
        chk("dphase_htrans", htrans, 2'b00);
        if (cur.wr) begin
          chk("hwdata", hwdata, cur.wdata);
          if (cur_idx < 16) log_wdata[cur_idx] = hwdata;
        end
        if (wait_left > 0) begin
          hready = 1'b0;
          wait_left--;
        end else begin
          hready = 1'b1;
          hrdata = cur.wr ? $urandom : cur.rdata;
          in_data = 0;
        end
      end else begin
        hready = 1'b1;
        if (htrans == 2'b10) begin
          cur_idx = xfer_cnt;
          if (xfer_cnt < 16) begin
            log_addr[xfer_cnt] = haddr;
            log_size[xfer_cnt] = hsize;
          end
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            fail("unexpected_xfer", $sformatf("got transfer to 0x%08h, required none", haddr));
          end else begin
            cur = exp_q.pop_front();
            chk("haddr", haddr, cur.addr);
            chk("hwrite", hwrite, cur.wr);
            chk("hsize", hsize, cur.size);
            if (!cur.wr && cur.addr == BASE) polls_seen++;
            in_data = 1;
            wait_left = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
          end
        end else begin
          chk("idle_htrans", htrans, 2'b00);
        end
      end
      if (rsp_valid) begin
        chk("rsp_expected", rsp_pending, 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_data", rsp_data, exp_data);
        chk("xfers_left", exp_q.size(), 0);
        chk("rsp_one_cycle", prev_rsp, 0);
        rsp_pending = 0;
        rsp_seen++;
      end else begin
        chk("rsp_err_idle", rsp_err, 0);
      end
      prev_rsp = rsp_valid;
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = req_ready;
    if (!ok) fail("ready_timeout", "got req_ready_o=0 for 100 cycles, required 1");
  endtask

  task automatic run_req(input logic [4:0] ss, input logic half, input logic [15:0] d,
                         input int done_at, input int wmode, input bit want_lat);
    bit ok;
    int lat;
    int start;
    wait_ready(ok);
    if (!ok) return;
    build(ss, half, d, done_at);
    wait_mode = wmode;
    xfer_cnt = 0;
    polls_seen = 0;
    req_valid = 1'b1;
    req_ss = ss;
    req_half = half;
    req_data = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_ss = 5'($urandom);
    req_half = 1'($urandom);
    req_data = 16'($urandom);
    lat = 0;
    start = rsp_seen;
    while (rsp_seen == start && lat < 2000) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (rsp_seen == start) fail("rsp_timeout", "got no response in 2000 cycles, required one");
    else if (want_lat) chk("latency", lat, 5 + 2 * RB);
  endtask

  task automatic reset_mid();
    bit ok;
    int n;
    wait_ready(ok);
    if (!ok) return;
    build(5'd3, 1'b1, 16'hbeef, 99);
    wait_mode = 3;
    xfer_cnt = 0;
    req_valid = 1'b1;
    req_ss = 5'd3;
    req_half = 1'b1;
    req_data = 16'hbeef;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!(htrans == 2'b10 && haddr == BASE && !hwrite) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("poll_timeout", "got no STATUS read in 200 cycles, required one");
    @(negedge clk);
    #1;
    chk("mid_hready_low", hready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_rst_htrans", htrans, 2'b00);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_rsp", rsp_valid, 0);
    exp_q.delete();
    rsp_pending = 0;
    m_cfg_done = 0;
    m_ss_valid = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] ss;
    ss = '0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_hsize", hsize, 3'd2);
    end
    rst = 1'b0;

    run_req(5'd0, 1'b1, 16'h1308, 2, 0, 0);
    chk("t2_xfers", xfer_cnt, 5 + RB);
    chk("t2_cfg_addr", log_addr[0], 32'h5200_0000);
    chk("t2_cfg_data", log_wdata[0], 32'h0000_2040);
    chk("t2_ss_addr", log_addr[1], 32'h5200_0004);
    chk("t2_ss_data", log_wdata[1], 32'h1);
    chk("t2_dat_addr", log_addr[2], 32'h5200_0008);
    chk("t2_dat_size", log_size[2], 3'd1);
    chk("t2_dat_data", log_wdata[2], 32'h1308);

    run_req(5'd0, 1'b1, 16'h1305, 1, 0, 1);
    chk("t3_xfers", xfer_cnt, 2 + RB);
    chk("t3_dat_data", log_wdata[0], 32'h1305);

    run_req(5'd2, 1'b0, 16'h0007, 1, 4, 0);
    chk("t4_ss_data", log_wdata[0], 32'h4);
    chk("t4_dat_size", log_size[1], 3'd0);
    chk("t4_dat_data", log_wdata[1], 32'h7);

    run_req(5'd5, 1'b1, 16'($urandom), 99, -1, 0);
    chk("t5_polls", polls_seen, 8);
    run_req(5'd5, 1'b1, 16'($urandom), 1, -1, 0);
    chk("t5_ss_rewrite", log_addr[0], 32'h5200_0004);
    chk("t5_xfers", xfer_cnt, 3 + RB);

    reset_mid();
    run_req(5'd3, 1'b1, 16'($urandom), 3, -1, 0);
    chk("t6_cfg_addr", log_addr[0], 32'h5200_0000);
    chk("t6_cfg_data", log_wdata[0], 32'h0000_2040);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) ss = 5'($urandom_range(0, 31));
      run_req(ss, 1'($urandom), 16'($urandom), $urandom_range(1, 10), -1, 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test by 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
